// File: rtl/accel_dm_pkg.sv
// Shared definitions for the accelerator data mover (input unpacker and output packer).
package accel_dm_pkg;

  localparam int unsigned DM_OF_BW  = 8;
  localparam int unsigned DM_PIXEL  = 4;
  localparam int unsigned DM_DWIDTH = DM_OF_BW * DM_PIXEL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dm_state_e;

  // Pixel counter must be able to hold the full frame length itself.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return int'($clog2(frame_len + 1));
  endfunction

endpackage

// File: rtl/data_pack.sv
// Packs PIXEL output pixels per stream word (lane 0 = first pixel) and frames one output fmap per i_run.
// Optional fused ReLU on the pixel input when DATA_PACK_RELU_EN is defined.
module data_pack
  import accel_dm_pkg::*;
#(
  parameter int unsigned OF_BW  = DM_OF_BW,
  parameter int unsigned DWIDTH = DM_DWIDTH,
  parameter int unsigned PIXEL  = DM_PIXEL,
  parameter int unsigned OUT_W  = 24,
  parameter int unsigned OUT_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [OF_BW-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              o_idle,
  output logic              o_done
);

  localparam int unsigned FRAME_LEN = OUT_W * OUT_H;
  localparam int unsigned CNT_W     = cnt_width(FRAME_LEN);
  localparam int unsigned PTR_W     = (PIXEL > 1) ? $clog2(PIXEL) : 1;

  dm_state_e         state_q, state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DWIDTH-1:0] pack_q;

  logic [OF_BW-1:0]  pix_c;
  logic [DWIDTH-1:0] word_c;
  logic              last_pix_c;
  logic              complete_c;
  logic              accept_c;
  logic              last_hs_c;

`ifdef DATA_PACK_RELU_EN
  assign pix_c = s_data[OF_BW-1] ? '0 : s_data;
`else
  assign pix_c = s_data;
`endif

  assign last_pix_c = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign complete_c = (ptr_q == PTR_W'(PIXEL - 1)) || last_pix_c;
  assign s_ready    = (state_q == RUN) && (cnt_q < CNT_W'(FRAME_LEN)) &&
                      !(complete_c && m_valid && !m_ready);
  assign accept_c   = s_valid && s_ready;
  assign last_hs_c  = m_valid && m_ready && m_last;

  // Word as it would look with the incoming pixel in lane ptr; lanes above ptr read as zero.
  always_comb begin
    word_c = '0;
    for (int i = 0; i < int'(PIXEL); i++) begin
      if (PTR_W'(i) == ptr_q) begin
        word_c[i*OF_BW +: OF_BW] = pix_c;
      end else if (PTR_W'(i) < ptr_q) begin
        word_c[i*OF_BW +: OF_BW] = pack_q[i*OF_BW +: OF_BW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_run) state_d = RUN;
      RUN: begin
        if (last_hs_c)                    state_d = DONE;
        else if (accept_c && last_pix_c)  state_d = FLUSH;
      end
      FLUSH:   if (last_hs_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      o_idle  <= 1'b1;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_idle  <= (state_d == IDLE);
      o_done  <= (state_d == DONE);

      if (state_q == IDLE && i_run) begin
        ptr_q <= '0;
        cnt_q <= '0;
      end else if (accept_c) begin
        pack_q <= word_c;
        ptr_q  <= complete_c ? '0 : ptr_q + PTR_W'(1);
        if (cnt_q != CNT_W'(FRAME_LEN)) cnt_q <= cnt_q + CNT_W'(1);
      end

      // Output holding register: s_ready guarantees it is free or draining on a load.
      if (accept_c && complete_c) begin
        m_data  <= word_c;
        m_valid <= 1'b1;
        m_last  <= last_pix_c;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// Directed self-checking bench for data_pack: default 24x24 frame instance plus a 5x1 partial-word instance.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run_a, i_run_b;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        m_ready;
  logic        sel_b;

  logic        s_ready_a, m_valid_a, m_last_a, o_idle_a, o_done_a;
  logic [31:0] m_data_a;
  logic        s_ready_b, m_valid_b, m_last_b, o_idle_b, o_done_b;
  logic [31:0] m_data_b;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];

  always #5 clk = ~clk;

  data_pack dut_a (
    .clk(clk), .rst(rst), .i_run(i_run_a),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
    .o_idle(o_idle_a), .o_done(o_done_a)
  );

  data_pack #(.OUT_W(5), .OUT_H(1)) dut_b (
    .clk(clk), .rst(rst), .i_run(i_run_b),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
    .o_idle(o_idle_b), .o_done(o_done_b)
  );

  // Word monitors: inputs change just after posedge, so a negedge sample matches the coming handshake.
  always @(negedge clk) begin
    if (m_valid_a && m_ready) q_a.push_back({m_last_a, m_data_a});
    if (m_valid_b && m_ready) q_b.push_back({m_last_b, m_data_b});
    if (o_done_a) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    s_data  = v;
    s_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (sel_b ? s_ready_b : s_ready_a) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL push_timeout: pixel %h never accepted", v);
    end
  endtask

  task automatic start(input bit b);
    sel_b = b;
    if (b) i_run_b = 1'b1; else i_run_a = 1'b1;
    tick();
    i_run_a = 1'b0;
    i_run_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] relu_exp;
    rst = 1'b1; i_run_a = 0; i_run_b = 0; s_data = 0; s_valid = 0; m_ready = 0; sel_b = 0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_m_data",  m_data_a, 32'h0);
    chk("rst_m_valid", 32'(m_valid_a), 32'h0);
    chk("rst_m_last",  32'(m_last_a), 32'h0);
    chk("rst_s_ready", 32'(s_ready_a), 32'h0);
    chk("rst_o_done",  32'(o_done_a), 32'h0);
    chk("rst_o_idle",  32'(o_idle_a), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // Basic packing with 1-cycle latency
    m_ready = 1'b1;
    start(0);
    chk("run_o_idle", 32'(o_idle_a), 32'h0);
    push(8'h01); push(8'h02); push(8'h03);
    @(negedge clk);
    chk("basic_no_early_valid", 32'(m_valid_a), 32'h0);
    tick();
    push(8'h04);
    @(negedge clk);
    chk("basic_valid", 32'(m_valid_a), 32'h1);
    chk("basic_data",  m_data_a, 32'h04030201);
    chk("basic_last",  32'(m_last_a), 32'h0);
    tick();
    do_reset();

    // ReLU lane write, then reset mid-frame after 7 pixels with a word held
`ifdef DATA_PACK_RELU_EN
    relu_exp = 32'h01007F00;
`else
    relu_exp = 32'h01FF7F80;
`endif
    m_ready = 1'b0;
    start(0);
    push(8'h80); push(8'h7F); push(8'hFF); push(8'h01);
    @(negedge clk);
    chk("relu_word", m_data_a, relu_exp);
    tick();
    push(8'h11); push(8'h12); push(8'h13);
    @(negedge clk);
    chk("pre_rst_valid", 32'(m_valid_a), 32'h1);
    tick();
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", 32'(m_valid_a), 32'h0);
    chk("post_rst_idle",  32'(o_idle_a), 32'h1);
    tick();

    // Full frame with a 10-cycle backpressure on the 2nd word
    q_a.delete();
    done_cnt = 0;
    m_ready = 1'b0;
    start(0);
    for (int i = 0; i < 7; i++) push(8'(i));
    s_data  = 8'h07;
    s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_s_ready", 32'(s_ready_a), 32'h0);
      chk("bp_hold_data", m_data_a, 32'h03020100);
      tick();
    end
    chk("bp_hold_valid", 32'(m_valid_a), 32'h1);
    m_ready = 1'b1;
    for (int i = 7; i < 576; i++) push(8'(i));
    for (int k = 0; k < 50 && !o_done_a; k++) @(negedge clk);
    chk("frame_o_done", 32'(o_done_a), 32'h1);
    tick();
    @(negedge clk);
    chk("frame_done_once", 32'(done_cnt), 32'h1);
    chk("frame_o_done_low", 32'(o_done_a), 32'h0);
    chk("frame_idle", 32'(o_idle_a), 32'h1);
    chk("frame_words", 32'(q_a.size()), 32'd144);
    for (int w = 0; w < q_a.size(); w++) begin
      exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      chk("frame_data", q_a[w][31:0], exp_w);
      chk("frame_last", 32'(q_a[w][32]), (w == 143) ? 32'h1 : 32'h0);
    end
    tick();

    // Partial final word on a 5-pixel frame
    q_b.delete();
    start(1);
    for (int i = 1; i <= 5; i++) push(8'(8'hA0 + i));
    for (int k = 0; k < 50 && !o_done_b; k++) @(negedge clk);
    chk("part_o_done", 32'(o_done_b), 32'h1);
    chk("part_words", 32'(q_b.size()), 32'd2);
    if (q_b.size() == 2) begin
      chk("part_w0",      q_b[0][31:0], 32'hA4A3A2A1);
      chk("part_w0_last", 32'(q_b[0][32]), 32'h0);
      chk("part_w1",      q_b[1][31:0], 32'h000000A5);
      chk("part_w1_last", 32'(q_b[1][32]), 32'h1);
    end
    tick();
    @(negedge clk);
    chk("part_idle", 32'(o_idle_b), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
